// File: rtl/order_dispenser_pkg.sv
// Shared definitions for the order dispenser: FSM states, menu category
// bit positions, default dispense durations and a one-hot test helper.
package order_dispenser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam int unsigned DISH  = 2;
  localparam int unsigned SIDE  = 1;
  localparam int unsigned DRINK = 0;

  localparam int unsigned DEF_DISH_T  = 6;
  localparam int unsigned DEF_SIDE_T  = 4;
  localparam int unsigned DEF_DRINK_T = 3;

  function automatic logic onehot3(input logic [2:0] v);
    return (v != 3'b000) && ((v & (v - 3'd1)) == 3'b000);
  endfunction

endpackage

// File: rtl/order_dispenser_timer.sv
// Loadable down-counter for dispense duration; saturates at zero.
module dispense_timer #(
  parameter int unsigned CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          dec_i,
  input  logic [CW-1:0] load_val_i,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/order_dispenser.sv
// Consumes one confirmed order, strobes the dispensed item for a
// category-dependent number of cycles and counts completed dispenses.
module order_dispenser
  import order_dispenser_pkg::*;
#(
  parameter int unsigned DISH_T  = DEF_DISH_T,
  parameter int unsigned SIDE_T  = DEF_SIDE_T,
  parameter int unsigned DRINK_T = DEF_DRINK_T,
  parameter int unsigned CW      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       order_valid,
  output logic       order_ready,
  input  logic [2:0] menu,
  input  logic [2:0] item,
  input  logic       abort,
  output logic [2:0] disp,
  output logic       active,
  output logic       done,
  output logic       err,
  output logic       aborted,
  output logic [7:0] served_cnt
);

  state_e        state_q, state_d;
  logic [2:0]    item_q, item_d;
  logic          err_q, err_d;
  logic          aborted_q, aborted_d;
  logic [7:0]    served_q, served_d;
  logic          tmr_load, tmr_dec, tmr_zero;
  logic [CW-1:0] dur_m1;

  // Timer is loaded with T-1 so RUN lasts exactly T cycles (values T-1..0).
  always_comb begin
    dur_m1 = CW'(DRINK_T - 1);
    if (menu[DISH]) begin
      dur_m1 = CW'(DISH_T - 1);
    end else if (menu[SIDE]) begin
      dur_m1 = CW'(SIDE_T - 1);
    end
  end

  dispense_timer #(
    .CW(CW)
  ) u_timer (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (tmr_load),
    .dec_i      (tmr_dec),
    .load_val_i (dur_m1),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    item_d    = item_q;
    err_d     = 1'b0;
    aborted_d = 1'b0;
    served_d  = served_q;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (order_valid) begin
          if (onehot3(menu) && onehot3(item)) begin
            item_d   = item;
            tmr_load = 1'b1;
            state_d  = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        // Abort takes priority even on the final cycle, so no FIN follows.
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (tmr_zero) begin
          state_d = FIN;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      FIN: begin
        served_d = served_q + 8'd1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      item_q    <= '0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
      served_q  <= '0;
    end else begin
      state_q   <= state_d;
      item_q    <= item_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
      served_q  <= served_d;
    end
  end

  assign order_ready = (state_q == IDLE);
  assign active      = (state_q == RUN);
  assign done        = (state_q == FIN);
  assign disp        = (state_q == RUN) ? item_q : '0;
  assign err         = err_q;
  assign aborted     = aborted_q;
  assign served_cnt  = served_q;

endmodule
